// File: rtl/scrambler_if.sv
// AXI-Stream style beat bundle shared by the scrambler input and output.
// The master drives data/user/last/valid, the slave drives ready.
interface scrambler_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] tdata;
  logic [3:0]       tuser;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/scrambler.sv
// IEEE 802.11a DATA-field scrambler (x^7 + x^4 + 1).
// Each accepted WIDTH-bit beat is XORed with the frame-synchronous sequence,
// bit 0 first in time. The first beat of a frame starts from the seed port
// (or DEFAULT_SEED when the seed is zero, since all-zero locks the LFSR).
// Output is registered with one skid entry so downstream tready never
// reaches upstream tready combinationally.
module scrambler #(
  parameter int         WIDTH        = 24,
  parameter logic [6:0] DEFAULT_SEED = 7'h5D
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [6:0]  seed,
  scrambler_if.slave  s_axis,
  scrambler_if.master m_axis
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [6:0]       lfsr_q;
  logic [6:0]       beat_state;
  logic [6:0]       lfsr_v;
  logic [6:0]       lfsr_next;
  logic             fb;
  logic [WIDTH-1:0] scr_data;

  logic             accept;
  logic             emit;
  logic             ready_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [3:0]       out_user_q;
  logic             out_last_q;

  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [WIDTH-1:0] skid_data_q;
  logic [3:0]       skid_user_q;
  logic             skid_last_q;
  logic             out_free;

  assign accept   = s_axis.tvalid && ready_q;
  assign emit     = out_valid_q && m_axis.tready;
  assign out_free = !out_valid_q || emit;

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tuser  = out_user_q;
  assign m_axis.tlast  = out_last_q;

  // Pick the starting LFSR state for the beat on the input: seed at frame start, stored state mid-frame.
  always_comb begin
    beat_state = lfsr_q;
    if (state_q == IDLE) begin
      beat_state = (seed == 7'd0) ? DEFAULT_SEED : seed;
    end
  end

  // Unrolled scrambler: bit i sees the state after i shifts, and the final state is carried to the next beat.
  always_comb begin
    lfsr_v   = beat_state;
    fb       = 1'b0;
    scr_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fb          = lfsr_v[6] ^ lfsr_v[3];
      scr_data[i] = s_axis.tdata[i] ^ fb;
      lfsr_v      = {lfsr_v[5:0], fb};
    end
    lfsr_next = lfsr_v;
  end

  // Frame tracking: any accepted tlast ends the frame, any other accepted beat keeps it open.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = s_axis.tlast ? IDLE : ACTIVE;
    end
  end

  // Frame state and LFSR advance only when a beat is accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      lfsr_q  <= 7'h7F;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lfsr_q <= lfsr_next;
      end
    end
  end

  // Skid occupancy next cycle: filled when a beat arrives behind a held output, emptied when the output frees up.
  always_comb begin
    skid_valid_d = skid_valid_q;
    if (skid_valid_q && out_free) begin
      skid_valid_d = 1'b0;
    end else if (!skid_valid_q && accept && !out_free) begin
      skid_valid_d = 1'b1;
    end
  end

  // Output register and skid entry; data, rate and tlast always move together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_user_q  <= '0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= skid_data_q;
          out_user_q  <= skid_user_q;
          out_last_q  <= skid_last_q;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          out_data_q  <= scr_data;
          out_user_q  <= s_axis.tuser;
          out_last_q  <= s_axis.tlast;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_data_q <= scr_data;
        skid_user_q <= s_axis.tuser;
        skid_last_q <= s_axis.tlast;
      end
    end
  end

endmodule

// File: tb/tb_scrambler.sv
// Directed and randomised checks for the 802.11a scrambler with skid buffer.
module tb_scrambler;

  localparam int WIDTH = 24;

  logic       aclk;
  logic       areset;
  logic [6:0] seed;

  int n_checks;
  int n_fail;

  logic [28:0] exp_q[$];
  logic [28:0] cap_q[$];
  logic        model_active;
  logic [6:0]  model_lfsr;

  scrambler_if #(.WIDTH(WIDTH)) s_if ();
  scrambler_if #(.WIDTH(WIDTH)) m_if ();

  scrambler #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (7'h5D)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .seed   (seed),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  // Free-running clock, 10 ns period.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Bit-serial reference: returns {final_state, scrambled_beat}.
  function automatic logic [30:0] scr_model(input logic [6:0] st, input logic [23:0] d);
    logic [6:0]  s;
    logic [23:0] o;
    logic        f;
    s = st;
    o = '0;
    for (int i = 0; i < 24; i++) begin
      f    = s[6] ^ s[3];
      o[i] = d[i] ^ f;
      s    = {s[5:0], f};
    end
    return {s, o};
  endfunction

  // Reference model and output capture, sampled mid-cycle on the falling edge.
  initial begin
    logic [30:0] r;
    logic [6:0]  st;
    model_active = 1'b0;
    model_lfsr   = 7'h7F;
    forever begin
      @(negedge aclk);
      if (areset) begin
        model_active = 1'b0;
      end else begin
        if (s_if.tvalid && s_if.tready) begin
          st = model_active ? model_lfsr : ((seed == 7'd0) ? 7'h5D : seed);
          r  = scr_model(st, s_if.tdata);
          model_lfsr   = r[30:24];
          model_active = !s_if.tlast;
          exp_q.push_back({r[23:0], s_if.tuser, s_if.tlast});
        end
        if (m_if.tvalid && m_if.tready) begin
          cap_q.push_back({m_if.tdata, m_if.tuser, m_if.tlast});
        end
      end
    end
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_beat(input logic [23:0] d, input logic [3:0] u, input logic l, input logic [6:0] sd);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    seed        = sd;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic test_reset();
    areset      = 1'b1;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_tvalid: got %b expected 0", m_if.tvalid);
    end
    n_checks++;
    if (m_if.tdata !== 24'h000000) begin
      n_fail++;
      $display("[TB] FAIL reset_tdata: got %h expected 000000", m_if.tdata);
    end
    n_checks++;
    if (m_if.tuser !== 4'h0 || m_if.tlast !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_tuser_tlast: got %h/%b expected 0/0", m_if.tuser, m_if.tlast);
    end
    n_checks++;
    if (s_if.tready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_s_tready: got %b expected 0", s_if.tready);
    end
    s_if.tvalid = 1'b0;
    areset      = 1'b0;
    @(posedge aclk);
    #1;
    n_checks++;
    if (s_if.tready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_s_tready: got %b expected 1", s_if.tready);
    end
    clear_queues();
  endtask

  task automatic test_basic();
    m_if.tready = 1'b1;
    drive_beat(24'h000000, 4'b1011, 1'b0, 7'h7F);
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h934F70 || m_if.tlast !== 1'b0 || m_if.tuser !== 4'b1011) begin
      n_fail++;
      $display("[TB] FAIL basic_beat0: got v=%b d=%h u=%h l=%b expected v=1 d=934f70 u=b l=0",
               m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast);
    end
    drive_beat(24'h000000, 4'b1011, 1'b1, 7'h7F);
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h746440 || m_if.tlast !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_beat1: got v=%b d=%h l=%b expected v=1 d=746440 l=1",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_drained: got %b expected 0", m_if.tvalid);
    end
  endtask

  task automatic test_reseed();
    logic [6:0]  seeds[4];
    logic        lasts[4];
    logic [23:0] expd[4];
    seeds = '{7'h7F, 7'h33, 7'h7F, 7'h01};
    lasts = '{1'b0, 1'b1, 1'b0, 1'b1};
    expd  = '{24'h934F70, 24'h746440, 24'h934F70, 24'h746440};
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(24'h000000, 4'b1111, lasts[i], seeds[i]);
      @(posedge aclk);
      #1;
      n_checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== expd[i] || m_if.tlast !== lasts[i]) begin
        n_fail++;
        $display("[TB] FAIL reseed_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, m_if.tvalid, m_if.tdata, m_if.tlast, expd[i], lasts[i]);
      end
    end
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_default_seed();
    logic [6:0]  seeds[4];
    logic [23:0] din[4];
    logic [23:0] expd[4];
    seeds = '{7'h00, 7'h00, 7'h00, 7'h5D};
    din   = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000};
    expd  = '{24'h959836, 24'h959836, 24'h6A67C9, 24'h959836};
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(din[i], 4'b1011, 1'b1, seeds[i]);
      @(posedge aclk);
      #1;
      n_checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== expd[i] || m_if.tlast !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL default_seed_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=1",
                 i, m_if.tvalid, m_if.tdata, m_if.tlast, expd[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (m_if.tdata === din[0]) begin
          n_fail++;
          $display("[TB] FAIL default_seed_not_passthrough: got %h expected scrambled value", m_if.tdata);
        end
      end
    end
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [28:0] held;
    logic        rdy;
    int          k;
    int          edges;
    clear_queues();
    m_if.tready = 1'b0;
    k = 0;
    drive_beat(24'hA5A5A5, 4'b1111, 1'b0, 7'h2A);
    held = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      rdy = s_if.tready;
      @(posedge aclk);
      #1;
      if (s_if.tvalid && rdy) begin
        k++;
        if (k < 10) drive_beat(24'hA5A5A5 ^ (k * 24'h111111), 4'b1111, (k == 9), 7'h55);
        else s_if.tvalid = 1'b0;
      end
      if (cyc == 0) begin
        held = {m_if.tdata, m_if.tuser, m_if.tlast};
      end else begin
        n_checks++;
        if (m_if.tvalid !== 1'b1 || {m_if.tdata, m_if.tuser, m_if.tlast} !== held) begin
          n_fail++;
          $display("[TB] FAIL stall_stable_cyc%0d: got v=%b %h expected v=1 %h",
                   cyc, m_if.tvalid, {m_if.tdata, m_if.tuser, m_if.tlast}, held);
        end
      end
    end
    n_checks++;
    if (k != 2 || s_if.tready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_buffered: got accepted=%0d tready=%b expected accepted=2 tready=0", k, s_if.tready);
    end
    m_if.tready = 1'b1;
    edges = 0;
    while (cap_q.size() < 10 && edges < 40) begin
      rdy = s_if.tready;
      @(posedge aclk);
      #1;
      edges++;
      if (s_if.tvalid && rdy) begin
        k++;
        if (k < 10) drive_beat(24'hA5A5A5 ^ (k * 24'h111111), 4'b1111, (k == 9), 7'h55);
        else s_if.tvalid = 1'b0;
      end
      if (edges == 1) begin
        n_checks++;
        if (s_if.tready !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL drain_tready_rise: got %b expected 1", s_if.tready);
        end
      end
    end
    s_if.tvalid = 1'b0;
    n_checks++;
    if (edges != 10 || cap_q.size() != 10 || exp_q.size() != 10) begin
      n_fail++;
      $display("[TB] FAIL drain_throughput: got edges=%0d out=%0d in=%0d expected 10/10/10",
               edges, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < 10 && i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL backpressure_beat%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset_midframe();
    m_if.tready = 1'b0;
    drive_beat(24'h123456, 4'b1011, 1'b0, 7'h7F);
    @(posedge aclk);
    #1;
    drive_beat(24'h654321, 4'b1011, 1'b0, 7'h7F);
    @(posedge aclk);
    #1;
    drive_beat(24'hABCDEF, 4'b1011, 1'b0, 7'h7F);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset_flush: got tvalid=%b tready=%b expected 0/0", m_if.tvalid, s_if.tready);
    end
    areset      = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    clear_queues();
    @(posedge aclk);
    #1;
    drive_beat(24'h000000, 4'b1111, 1'b0, 7'h7F);
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h934F70) begin
      n_fail++;
      $display("[TB] FAIL midframe_restart_beat0: got v=%b d=%h expected v=1 d=934f70", m_if.tvalid, m_if.tdata);
    end
    drive_beat(24'h000000, 4'b1111, 1'b1, 7'h7F);
    @(posedge aclk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 24'h746440 || m_if.tlast !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midframe_restart_beat1: got v=%b d=%h l=%b expected v=1 d=746440 l=1",
               m_if.tvalid, m_if.tdata, m_if.tlast);
    end
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
    n_checks++;
    if (cap_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL midframe_no_stale: got %0d beats expected 2", cap_q.size());
    end
  endtask

  task automatic test_random();
    int         len;
    int         idle;
    int         wait_cnt;
    logic [6:0] fseed;
    logic [3:0] rate;
    logic       rdy;
    logic       timed_out;
    clear_queues();
    timed_out = 1'b0;
    for (int f = 0; f < 200 && !timed_out; f++) begin
      len   = $urandom_range(1, 6);
      fseed = (f % 17 == 0) ? 7'h00 : 7'($urandom_range(0, 127));
      rate  = (f % 3 == 0) ? 4'b1011 : ((f % 3 == 1) ? 4'b1111 : 4'($urandom_range(0, 15)));
      for (int b = 0; b < len && !timed_out; b++) begin
        idle = $urandom_range(0, 2);
        for (int c = 0; c < idle; c++) begin
          s_if.tvalid = 1'b0;
          m_if.tready = ($urandom_range(0, 3) != 0);
          @(posedge aclk);
          #1;
        end
        drive_beat(24'($urandom()), rate, (b == len - 1), (b == 0) ? fseed : 7'($urandom_range(0, 127)));
        wait_cnt = 0;
        rdy      = 1'b0;
        while (!rdy && wait_cnt < 100) begin
          m_if.tready = ($urandom_range(0, 3) != 0);
          rdy = s_if.tready;
          @(posedge aclk);
          #1;
          wait_cnt++;
        end
        if (!rdy) begin
          timed_out = 1'b1;
          n_checks++;
          n_fail++;
          $display("[TB] FAIL random_accept_timeout: got no accept expected accept within 100 cycles");
        end
      end
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    wait_cnt    = 0;
    while (cap_q.size() < exp_q.size() && wait_cnt < 50) begin
      @(posedge aclk);
      #1;
      wait_cnt++;
    end
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL random_count: got %0d beats expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL random_beat%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  // Test sequence.
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    areset      = 1'b1;
    seed        = 7'h00;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    $display("[TB] starting scrambler tests");
    test_reset();
    test_basic();
    test_reseed();
    test_default_seed();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
